// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/LS memory port arbiter: FSM states,
// access owner and starvation counter width.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    MEMARB_IDLE   = 2'd0,
    MEMARB_ACCESS = 2'd1,
    MEMARB_RESP   = 2'd2
  } memarb_state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LS = 1'b1
  } memarb_owner_e;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arb_age_counter.sv
// Saturating count of LS grants made while IF waits; limit_o tells the
// arbiter that IF must win the next arbitration.
module mem_arb_age_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic limit_o
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  // Next count: clear wins over increment, increment saturates at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {STARVE_CNT_W{1'b0}};
    end else if (inc_i && (cnt_q < LIMIT_C)) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {STARVE_CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store;
// one registered access at a time, with flush-driven response dropping.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_flush,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_stall,
  input  logic                    ls_req,
  input  logic                    ls_we,
  input  logic [ADDR_WIDTH-1:0]   ls_addr,
  input  logic [DATA_WIDTH-1:0]   ls_wdata,
  input  logic [DATA_WIDTH/8-1:0] ls_be,
  output logic                    ls_rvalid,
  output logic [DATA_WIDTH-1:0]   ls_rdata,
  output logic                    ls_stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int BE_W = DATA_WIDTH / 8;

  memarb_state_e           state_q, state_d;
  memarb_owner_e           owner_q, owner_d;
  logic                    drop_q, drop_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]         mem_be_q, mem_be_d;
  logic                    if_rvalid_q, if_rvalid_d;
  logic                    ls_rvalid_q, ls_rvalid_d;
  logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]   ls_rdata_q, ls_rdata_d;

  logic if_ok_s;
  logic grant_if_s;
  logic grant_ls_s;
  logic starve_full_s;
  logic starve_inc_s;
  logic starve_clr_s;

  // A flushed fetch is never granted in the cycle the flush is seen
  assign if_ok_s      = if_req & ~if_flush;
  assign starve_inc_s = grant_ls_s & if_req;
  assign starve_clr_s = grant_if_s | ~if_req;

  mem_arb_age_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_age (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (starve_inc_s),
    .clr_i   (starve_clr_s),
    .limit_o (starve_full_s)
  );

  // Arbitration, only evaluated while idle
  always_comb begin
    grant_if_s = 1'b0;
    grant_ls_s = 1'b0;
    if (state_q == MEMARB_IDLE) begin
      if (starve_full_s && if_ok_s) begin
        grant_if_s = 1'b1;
      end else if (ls_req) begin
        grant_ls_s = 1'b1;
      end else if (if_ok_s) begin
        grant_if_s = 1'b1;
      end else begin
        grant_if_s = 1'b0;
      end
    end else begin
      grant_ls_s = 1'b0;
    end
  end

  // FSM next state, request mux and response demux
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    case (state_q)
      MEMARB_IDLE: begin
        if (grant_if_s) begin
          owner_d     = OWNER_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = {DATA_WIDTH{1'b0}};
          mem_be_d    = {BE_W{1'b1}};
          state_d     = MEMARB_ACCESS;
        end else if (grant_ls_s) begin
          owner_d     = OWNER_LS;
          mem_req_d   = 1'b1;
          mem_we_d    = ls_we;
          mem_addr_d  = ls_addr;
          mem_wdata_d = ls_wdata;
          mem_be_d    = ls_be;
          state_d     = MEMARB_ACCESS;
        end else begin
          state_d = MEMARB_IDLE;
        end
      end
      MEMARB_ACCESS: begin
        // A flush coinciding with mem_ready still drops the fetch response
        drop_d = drop_q | ((owner_q == OWNER_IF) & if_flush);
        if (mem_ready) begin
          mem_req_d = 1'b0;
          if (owner_q == OWNER_LS) begin
            ls_rdata_d = mem_we_q ? {DATA_WIDTH{1'b0}} : mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
          if (drop_d) begin
            drop_d  = 1'b0;
            state_d = MEMARB_IDLE;
          end else begin
            if_rvalid_d = (owner_q == OWNER_IF);
            ls_rvalid_d = (owner_q == OWNER_LS);
            state_d     = MEMARB_RESP;
          end
        end else begin
          state_d = MEMARB_ACCESS;
        end
      end
      MEMARB_RESP: begin
        state_d = MEMARB_IDLE;
      end
      default: begin
        state_d   = MEMARB_IDLE;
        mem_req_d = 1'b0;
        drop_d    = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MEMARB_IDLE;
      owner_q     <= OWNER_IF;
      drop_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q <= {DATA_WIDTH{1'b0}};
      mem_be_q    <= {BE_W{1'b0}};
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= {DATA_WIDTH{1'b0}};
      ls_rdata_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign if_stall  = if_req & ~if_rvalid_q;
  assign ls_stall  = ls_req & ~ls_rvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: loads, stores, starvation order,
// flush dropping, reset mid-access and minimum latency.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_be;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        ls_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .if_stall  (if_stall),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_be     (ls_be),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .ls_stall  (ls_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_be = 4'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    step(); step();

    // Reset state
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_if_rvalid", if_rvalid, 1'b0);
    chk1("rst_ls_rvalid", ls_rvalid, 1'b0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    chk32("rst_ls_rdata", ls_rdata, 32'h0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_be", {28'h0, mem_be}, 32'h0);
    reset = 1'b0;
    step();

    // Single load, memory answers two cycles after mem_req
    ls_req = 1'b1; ls_addr = 32'h100; ls_we = 1'b0;
    #1;
    chk1("ld_stall_idle", ls_stall, 1'b1);
    step();
    chk1("ld_mem_req", mem_req, 1'b1);
    chk32("ld_mem_addr", mem_addr, 32'h100);
    chk1("ld_mem_we", mem_we, 1'b0);
    step();
    chk1("ld_stall_wait", ls_stall, 1'b1);
    step();
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    chk1("ld_no_early_rvalid", ls_rvalid, 1'b0);
    step();
    chk1("ld_rvalid", ls_rvalid, 1'b1);
    chk32("ld_rdata", ls_rdata, 32'hDEADBEEF);
    chk1("ld_stall_cleared", ls_stall, 1'b0);
    chk1("ld_mem_req_drop", mem_req, 1'b0);
    mem_ready = 1'b0; ls_req = 1'b0;
    step();
    chk1("ld_rvalid_one_cycle", ls_rvalid, 1'b0);
    chk32("ld_rdata_hold", ls_rdata, 32'hDEADBEEF);

    // Starvation: LS x4 then IF, twice; second round proves the counter reset
    if_req = 1'b1; if_addr = 32'h200; ls_req = 1'b1; ls_addr = 32'h300;
    mem_ready = 1'b1; mem_rdata = 32'hA5A5A5A5;
    for (int k = 0; k < 10; k++) begin
      step();
      chk1("starve_mem_req", mem_req, 1'b1);
      chk32("starve_grant_addr", mem_addr, ((k % 5) == 4) ? 32'h200 : 32'h300);
      step();
      chk1("starve_if_rvalid", if_rvalid, (k % 5) == 4);
      chk1("starve_ls_rvalid", ls_rvalid, (k % 5) != 4);
      step();
    end
    chk32("starve_if_rdata", if_rdata, 32'hA5A5A5A5);
    if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b0;
    step();

    // Flush during IF access drops the response; next fetch is served
    if_req = 1'b1; if_addr = 32'h40;
    step();
    chk32("fl_mem_addr", mem_addr, 32'h40);
    if_flush = 1'b1;
    step();
    if_flush = 1'b0; if_addr = 32'h80;
    mem_ready = 1'b1; mem_rdata = 32'h11111111;
    chk32("fl_addr_held", mem_addr, 32'h40);
    step();
    chk1("fl_no_rvalid", if_rvalid, 1'b0);
    chk1("fl_mem_req_low", mem_req, 1'b0);
    mem_ready = 1'b0;
    step();
    chk1("fl_new_req", mem_req, 1'b1);
    chk32("fl_new_addr", mem_addr, 32'h80);
    mem_ready = 1'b1; mem_rdata = 32'h22222222;
    step();
    chk1("fl_new_rvalid", if_rvalid, 1'b1);
    chk32("fl_new_rdata", if_rdata, 32'h22222222);
    mem_ready = 1'b0; if_req = 1'b0;
    step();

    // Flush coinciding with mem_ready drops; flush in IDLE blocks the IF grant
    if_req = 1'b1; if_addr = 32'h44;
    step();
    chk1("flr_mem_req", mem_req, 1'b1);
    mem_ready = 1'b1; if_flush = 1'b1;
    step();
    chk1("flr_no_rvalid", if_rvalid, 1'b0);
    mem_ready = 1'b0;
    step();
    chk1("flr_idle_no_grant", mem_req, 1'b0);
    if_flush = 1'b0; if_req = 1'b0;
    step();

    // Store: byte enables forwarded, ls_rdata zero, if_rdata untouched
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h10; ls_wdata = 32'h1234; ls_be = 4'b0011;
    step();
    chk1("st_mem_we", mem_we, 1'b1);
    chk32("st_mem_be", {28'h0, mem_be}, 32'h3);
    chk32("st_mem_wdata", mem_wdata, 32'h1234);
    mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    step();
    chk1("st_rvalid", ls_rvalid, 1'b1);
    chk32("st_rdata_zero", ls_rdata, 32'h0);
    chk32("st_if_rdata_kept", if_rdata, 32'h22222222);
    mem_ready = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    step();

    // Minimum latency: mem_ready already high when mem_req first rises
    if_req = 1'b1; if_addr = 32'h300; mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    chk1("lat_req_n1", mem_req, 1'b1);
    chk1("lat_rvalid_n1", if_rvalid, 1'b0);
    step();
    chk1("lat_rvalid_n2", if_rvalid, 1'b1);
    chk32("lat_rdata", if_rdata, 32'hCAFEF00D);
    if_req = 1'b0; mem_ready = 1'b0;
    step();

    // Reset mid-access abandons the request
    ls_req = 1'b1; ls_addr = 32'h500;
    step();
    chk1("rma_mem_req", mem_req, 1'b1);
    reset = 1'b1;
    step();
    chk1("rma_req_low", mem_req, 1'b0);
    chk32("rma_if_rdata", if_rdata, 32'h0);
    chk32("rma_mem_addr", mem_addr, 32'h0);
    reset = 1'b0; ls_req = 1'b0; mem_ready = 1'b1;
    step();
    chk1("rma_late_ready_ignored", mem_req, 1'b0);
    mem_ready = 1'b0;
    step();
    chk1("rma_no_ls_rvalid", ls_rvalid, 1'b0);
    chk1("rma_no_if_rvalid", if_rvalid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
